// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midi_pkg
// Description : Shared constants and types for the MIDI voice allocator:
//               channel-message type codes, channel-mode CC numbers, the
//               allocator FSM state encoding and the internal message record.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

  // Status nibble bits [6:4] as delivered by the byte parser
  localparam logic [2:0] MSG_NOTE_OFF = 3'b000;
  localparam logic [2:0] MSG_NOTE_ON  = 3'b001;
  localparam logic [2:0] MSG_CC       = 3'b011;

  // Channel-mode controller numbers that silence every voice
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Decoded operation; Note On with velocity 0 is already folded into
  // OP_NOTE_OFF, and both silencing CCs become OP_ALL_OFF.
  typedef enum logic [1:0] {
    OP_NOTE_OFF = 2'd0,
    OP_NOTE_ON  = 2'd1,
    OP_ALL_OFF  = 2'd2
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [6:0] note;
    logic [6:0] vel;
  } msg_t;

endpackage
`default_nettype wire

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : midi_voice_allocator
// Description : Polyphonic note-to-voice allocator. Takes assembled channel
//               messages from the MIDI parser and maintains a table of
//               NUM_VOICES voices (note, velocity, gate, trigger). Note On
//               retriggers a matching sounding voice, else takes the lowest
//               free voice, else steals round-robin. Note Off releases all
//               matching voices. CC 120/123 releases every voice.
// Ports       : clk_in, rst_in          clock, synchronous active-high reset
//               msg_type_in[2:0]        status bits [6:4]
//               data_byte1_in[7:0]      note / CC number (bit 7 ignored)
//               data_byte2_in[7:0]      velocity / CC value (bit 7 ignored)
//               valid_in                level valid, message on 0->1 edge
//               voice_note_out          7 bits per voice, voice i at [7i+:7]
//               voice_vel_out           7 bits per voice, same packing
//               voice_gate_out          per-voice gate
//               voice_trig_out          per-voice one-cycle start pulse
//               busy_out                message in progress
//               drop_out                one-cycle pulse, message lost
// Revision    : 1.0 - initial release
// ============================================================================
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [2:0]                msg_type_in,
  input  logic [7:0]                data_byte1_in,
  input  logic [7:0]                data_byte2_in,
  input  logic                      valid_in,
  output logic [7*NUM_VOICES-1:0]   voice_note_out,
  output logic [7*NUM_VOICES-1:0]   voice_vel_out,
  output logic [NUM_VOICES-1:0]     voice_gate_out,
  output logic [NUM_VOICES-1:0]     voice_trig_out,
  output logic                      busy_out,
  output logic                      drop_out
);

  localparam int            IW       = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

  // --------------------------------------------------------------------------
  // Input edge detection and decode
  // --------------------------------------------------------------------------
  logic   valid_q;
  logic   event_edge;
  logic   in_relevant;
  logic   new_ev;
  msg_t   in_msg;
  logic   unused_bits;

  assign event_edge  = valid_in & ~valid_q;
  assign new_ev      = event_edge & in_relevant;
  assign unused_bits = ^{data_byte1_in[7], data_byte2_in[7]};

  always_comb begin
    in_msg.op   = OP_NOTE_OFF;
    in_msg.note = data_byte1_in[6:0];
    in_msg.vel  = data_byte2_in[6:0];
    in_relevant = 1'b0;
    case (msg_type_in)
      MSG_NOTE_OFF: in_relevant = 1'b1;
      MSG_NOTE_ON: begin
        in_relevant = 1'b1;
        if (data_byte2_in[6:0] != 7'd0) in_msg.op = OP_NOTE_ON;
      end
      MSG_CC: begin
        if (data_byte1_in[6:0] == CC_ALL_SOUND_OFF ||
            data_byte1_in[6:0] == CC_ALL_NOTES_OFF) begin
          in_relevant = 1'b1;
          in_msg.op   = OP_ALL_OFF;
        end
      end
      default: in_relevant = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t          state, next_state;
  msg_t            cur_msg;
  msg_t            pend_msg;
  logic            pend_valid;
  msg_t            launch_msg;
  logic            launch;
  logic [IW-1:0]   idx;
  logic            match_found, free_found;
  logic [IW-1:0]   match_idx, free_idx;
  logic [IW-1:0]   steal_ptr;
  logic [IW-1:0]   chosen;

  // Voice table
  logic [6:0]             note_q [NUM_VOICES];
  logic [6:0]             vel_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]  gate_q;
  logic [NUM_VOICES-1:0]  trig_q;
  logic                   drop_q;

  // A held message always takes precedence over a fresh edge; in IDLE with an
  // empty slot the fresh edge is started immediately. A fresh edge seen on
  // the COMMIT cycle lands in the slot rather than starting here.
  assign launch = ((state == ST_IDLE) && (pend_valid || new_ev)) ||
                  ((state == ST_COMMIT) && pend_valid);
  assign launch_msg = pend_valid ? pend_msg : in_msg;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (launch)
          next_state = (launch_msg.op == OP_ALL_OFF) ? ST_COMMIT : ST_SCAN;
      end
      ST_SCAN: begin
        if (idx == LAST_IDX) next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (launch)
          next_state = (launch_msg.op == OP_ALL_OFF) ? ST_COMMIT : ST_SCAN;
        else
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy_out = (state != ST_IDLE);

  // Message capture, pending slot and per-voice scan accumulators
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= 1'b0;
      cur_msg     <= '0;
      pend_msg    <= '0;
      pend_valid  <= 1'b0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      drop_q      <= 1'b0;
    end else begin
      valid_q <= valid_in;
      drop_q  <= 1'b0;

      if (launch) begin
        cur_msg     <= launch_msg;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        match_idx   <= '0;
        free_idx    <= '0;
      end

      if (launch && pend_valid) begin
        // Slot is vacated by this launch, so a simultaneous edge refills it
        // without loss.
        pend_valid <= new_ev;
        if (new_ev) pend_msg <= in_msg;
      end else if (!launch && new_ev) begin
        pend_msg   <= in_msg;
        pend_valid <= 1'b1;
        if (pend_valid) drop_q <= 1'b1;
      end

      if (state == ST_SCAN) begin
        idx <= idx + 1'b1;
        if (!match_found && gate_q[idx] && (note_q[idx] == cur_msg.note)) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!free_found && !gate_q[idx]) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
      end
    end
  end

  always_comb begin
    chosen = steal_ptr;
    if (match_found)     chosen = match_idx;
    else if (free_found) chosen = free_idx;
  end

  // Voice table update, applied only on the COMMIT cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
      gate_q    <= '0;
      trig_q    <= '0;
      steal_ptr <= '0;
    end else begin
      trig_q <= '0;
      if (state == ST_COMMIT) begin
        case (cur_msg.op)
          OP_NOTE_ON: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IW'(i) == chosen) begin
                note_q[i] <= cur_msg.note;
                vel_q[i]  <= cur_msg.vel;
                gate_q[i] <= 1'b1;
                trig_q[i] <= 1'b1;
              end
            end
            if (!match_found && !free_found)
              steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + 1'b1;
          end
          OP_NOTE_OFF: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (gate_q[i] && (note_q[i] == cur_msg.note)) gate_q[i] <= 1'b0;
            end
          end
          OP_ALL_OFF: gate_q <= '0;
          default: gate_q <= gate_q;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output packing
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note_out[7*g +: 7] = note_q[g];
    assign voice_vel_out[7*g +: 7]  = vel_q[g];
  end

  assign voice_gate_out = gate_q;
  assign voice_trig_out = trig_q;
  assign drop_out       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_voice_allocator
// Description : Self-checking bench for midi_voice_allocator (4 voices):
//               reset state, a table of messages with expected voice tables,
//               hand-written timing sequences, and random messages compared
//               against a behavioural voice model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [2:0]        msg_type_in;
  logic [7:0]        data_byte1_in;
  logic [7:0]        data_byte2_in;
  logic              valid_in;
  logic [7*NV-1:0]   voice_note_out;
  logic [7*NV-1:0]   voice_vel_out;
  logic [NV-1:0]     voice_gate_out;
  logic [NV-1:0]     voice_trig_out;
  logic              busy_out;
  logic              drop_out;

  midi_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .msg_type_in    (msg_type_in),
    .data_byte1_in  (data_byte1_in),
    .data_byte2_in  (data_byte2_in),
    .valid_in       (valid_in),
    .voice_note_out (voice_note_out),
    .voice_vel_out  (voice_vel_out),
    .voice_gate_out (voice_gate_out),
    .voice_trig_out (voice_trig_out),
    .busy_out       (busy_out),
    .drop_out       (drop_out)
  );

  always #5 clk_in = ~clk_in;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  logic [6:0]    m_note [NV];
  logic [6:0]    m_vel  [NV];
  logic [NV-1:0] m_gate;
  int            m_ptr;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = '0;
      m_vel[i]  = '0;
    end
    m_gate = '0;
    m_ptr  = 0;
  endtask

  task automatic model_apply(input logic [2:0] t, input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] n;
    logic [6:0] v;
    int sel;
    n = b1[6:0];
    v = b2[6:0];
    sel = -1;
    if (t == 3'd1 && v != 0) begin
      for (int i = 0; i < NV; i++)
        if (sel < 0 && m_gate[i] && m_note[i] == n) sel = i;
      for (int i = 0; i < NV; i++)
        if (sel < 0 && !m_gate[i]) sel = i;
      if (sel < 0) begin
        sel   = m_ptr;
        m_ptr = (m_ptr + 1) % NV;
      end
      m_note[sel] = n;
      m_vel[sel]  = v;
      m_gate[sel] = 1'b1;
    end else if (t == 3'd0 || t == 3'd1) begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
    end else if (t == 3'd3 && (n == 7'd120 || n == 7'd123)) begin
      m_gate = '0;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    @(negedge clk_in);
    rst_in   = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  // Presents one message edge; returns at the sample point of cycle 1.
  task automatic send(input logic [2:0] t, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk_in);
    msg_type_in   = t;
    data_byte1_in = b1;
    data_byte2_in = b2;
    valid_in      = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [3:0]  gate;
    logic [27:0] notes;
    logic [27:0] vels;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [27:0] en, ev;
    logic [2:0]  rt;
    logic [7:0]  rb1, rb2;
    int          r, drops;

    // notes/vels packed {voice3, voice2, voice1, voice0}
    tbl[0]  = '{3'd1, 8'd60,  8'd100, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd60},   {7'd0, 7'd0, 7'd0, 7'd100}};
    tbl[1]  = '{3'd1, 8'd62,  8'd90,  4'b0011, {7'd0, 7'd0, 7'd62, 7'd60},  {7'd0, 7'd0, 7'd90, 7'd100}};
    tbl[2]  = '{3'd1, 8'd64,  8'd80,  4'b0111, {7'd0, 7'd64, 7'd62, 7'd60}, {7'd0, 7'd80, 7'd90, 7'd100}};
    tbl[3]  = '{3'd1, 8'd65,  8'd70,  4'b1111, {7'd65, 7'd64, 7'd62, 7'd60}, {7'd70, 7'd80, 7'd90, 7'd100}};
    tbl[4]  = '{3'd1, 8'd67,  8'd60,  4'b1111, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd70, 7'd80, 7'd90, 7'd60}};
    tbl[5]  = '{3'd0, 8'd62,  8'd0,   4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd70, 7'd80, 7'd90, 7'd60}};
    tbl[6]  = '{3'd1, 8'd62,  8'd0,   4'b1101, {7'd65, 7'd64, 7'd62, 7'd67}, {7'd70, 7'd80, 7'd90, 7'd60}};
    tbl[7]  = '{3'd1, 8'd70,  8'd50,  4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, {7'd70, 7'd80, 7'd50, 7'd60}};
    tbl[8]  = '{3'd1, 8'd64,  8'd40,  4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, {7'd70, 7'd40, 7'd50, 7'd60}};
    tbl[9]  = '{3'd3, 8'd7,   8'd100, 4'b1111, {7'd65, 7'd64, 7'd70, 7'd67}, {7'd70, 7'd40, 7'd50, 7'd60}};
    tbl[10] = '{3'd3, 8'd123, 8'd0,   4'b0000, {7'd65, 7'd64, 7'd70, 7'd67}, {7'd70, 7'd40, 7'd50, 7'd60}};
    tbl[11] = '{3'd1, 8'hC8,  8'h9E,  4'b0001, {7'd65, 7'd64, 7'd70, 7'd72}, {7'd70, 7'd40, 7'd50, 7'd30}};
    tbl[12] = '{3'd2, 8'd72,  8'd99,  4'b0001, {7'd65, 7'd64, 7'd70, 7'd72}, {7'd70, 7'd40, 7'd50, 7'd30}};
    tbl[13] = '{3'd3, 8'd120, 8'd0,   4'b0000, {7'd65, 7'd64, 7'd70, 7'd72}, {7'd70, 7'd40, 7'd50, 7'd30}};

    rst_in = 1'b1; valid_in = 1'b0;
    msg_type_in = '0; data_byte1_in = '0; data_byte2_in = '0;

    // Reset state
    do_reset();
    check("reset_note", voice_note_out, 0);
    check("reset_vel",  voice_vel_out,  0);
    check("reset_gate", voice_gate_out, 0);
    check("reset_trig", voice_trig_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_drop", drop_out, 0);

    // First Note On: busy cycles 1-5, trig/gate visible in cycle 6
    send(3'd1, 8'd60, 8'd100);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("on_busy_c%0d", k), busy_out, (k <= 5) ? 1 : 0);
      check($sformatf("on_trig_c%0d", k), voice_trig_out, (k == 6) ? 1 : 0);
      check($sformatf("on_gate_c%0d", k), voice_gate_out, (k >= 6) ? 1 : 0);
      @(negedge clk_in);
    end
    check("on_note0", voice_note_out[6:0], 60);
    check("on_vel0",  voice_vel_out[6:0], 100);

    // Table-driven messages from a clean voice table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].t, tbl[i].b1, tbl[i].b2);
      repeat (8) @(negedge clk_in);
      check($sformatf("tbl%0d_gate", i),  voice_gate_out, tbl[i].gate);
      check($sformatf("tbl%0d_notes", i), voice_note_out, tbl[i].notes);
      check($sformatf("tbl%0d_vels", i),  voice_vel_out,  tbl[i].vels);
    end

    // All-notes-off timing, then an ignored CC never raises busy
    do_reset();
    send(3'd1, 8'd60, 8'd10); repeat (8) @(negedge clk_in);
    send(3'd1, 8'd61, 8'd11); repeat (8) @(negedge clk_in);
    send(3'd1, 8'd62, 8'd12); repeat (8) @(negedge clk_in);
    send(3'd1, 8'd63, 8'd13); repeat (8) @(negedge clk_in);
    check("ano_pre_gate", voice_gate_out, 4'b1111);
    send(3'd3, 8'd123, 8'd0);
    check("ano_c1_busy", busy_out, 1);
    check("ano_c1_gate", voice_gate_out, 4'b1111);
    @(negedge clk_in);
    check("ano_c2_busy", busy_out, 0);
    check("ano_c2_gate", voice_gate_out, 4'b0000);
    send(3'd3, 8'd7, 8'd64);
    check("cc7_c1_busy", busy_out, 0);
    @(negedge clk_in);
    check("cc7_c2_busy", busy_out, 0);
    check("cc7_gate", voice_gate_out, 4'b0000);

    // Burst: second edge held, third overwrites it and is the one processed
    do_reset();
    send(3'd1, 8'd60, 8'd100);
    drops = 0;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("burst_busy_c%0d", k), busy_out, (k <= 10) ? 1 : 0);
      if (drop_out) drops++;
      if (k == 5) check("burst_drop_c5", drop_out, 1);
      if (k == 2) begin
        msg_type_in = 3'd1; data_byte1_in = 8'd62; data_byte2_in = 8'd90; valid_in = 1'b1;
      end else if (k == 4) begin
        msg_type_in = 3'd1; data_byte1_in = 8'd64; data_byte2_in = 8'd80; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk_in);
    end
    check("burst_drop_count", drops, 1);
    check("burst_gate", voice_gate_out, 4'b0011);
    check("burst_note1", voice_note_out[13:7], 64);
    check("burst_vel1",  voice_vel_out[13:7], 80);

    // Reset in the middle of a scan abandons the message
    send(3'd1, 8'd66, 8'd55);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid_rst_note", voice_note_out, 0);
    check("mid_rst_vel",  voice_vel_out, 0);
    check("mid_rst_gate", voice_gate_out, 0);
    check("mid_rst_busy", busy_out, 0);
    rst_in = 1'b0;
    repeat (8) @(negedge clk_in);
    check("mid_rst_after_gate", voice_gate_out, 0);
    check("mid_rst_after_note", voice_note_out, 0);

    // Random messages against the behavioural model
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 9);
      rb1 = 8'(60 + $urandom_range(0, 5)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      rb2 = 8'($urandom_range(1, 127))    | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      if (r <= 4)      rt = 3'd1;
      else if (r <= 6) rt = 3'd0;
      else if (r == 7) begin
        rt = 3'd3;
        case ($urandom_range(0, 2))
          0:       rb1 = 8'd7;
          1:       rb1 = 8'd120;
          default: rb1 = 8'd123;
        endcase
      end else if (r == 8) begin
        rt = 3'(4 + $urandom_range(0, 3));
        if (rt == 3'd4) rt = 3'd2;
      end else begin
        rt  = 3'd1;
        rb2 = 8'h80;
      end
      send(rt, rb1, rb2);
      model_apply(rt, rb1, rb2);
      repeat (8) @(negedge clk_in);
      for (int i = 0; i < NV; i++) begin
        en[7*i +: 7] = m_note[i];
        ev[7*i +: 7] = m_vel[i];
      end
      check($sformatf("rnd%0d_gate", n),  voice_gate_out, m_gate);
      check($sformatf("rnd%0d_notes", n), voice_note_out, en);
      check($sformatf("rnd%0d_vels", n),  voice_vel_out,  ev);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
